condlogic_mc: RTL and testbench
===============================

Name: condlogic_mc

Overview:
Condition unit for the multicycle ARM core. It receives the unconditional control strobes from the instruction decoder (FlagW, PCS, NextPC, RegW, MemW) and the ALU flags from the datapath. It holds the architectural NZCV flags, evaluates the 4-bit condition field, and produces the final write enables PCWrite, RegWrite and MemWrite. The condition result is registered so it stays valid in the later FSM states of the same instruction.

Parameters:
FLAG_RESET, 4'b0000, value loaded into {N,Z,C,V} on reset.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
Cond  input  4  condition field Instr[31:28]
ALUFlags  input  4  {N,Z,C,V} from the ALU in the current cycle
FlagW  input  2  from decoder; [1] enables the N,Z update, [0] enables the C,V update
PCS  input  1  from decoder; PC written by a branch or by a write to R15
NextPC  input  1  from FSM; unconditional PC increment (fetch state)
RegW  input  1  from FSM; register-file write request
MemW  input  1  from FSM; memory write request
PCWrite  output  1  final PC enable
RegWrite  output  1  final register-file write enable
MemWrite  output  1  final memory write enable
Flags  output  4  current architectural {N,Z,C,V}, for observation and debug

Behaviour:
- Reset, synchronous on clk, dominates all other inputs:
  - Flags <= FLAG_RESET.
  - CondExReg <= 0.
  - Because CondExReg is 0 on the cycle after reset, PCWrite = NextPC, RegWrite = 0 and MemWrite = 0.
- CondEx (combinational) is evaluated from Cond and the current Flags:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 1 (treated as unconditional; never X)
- Flag update, each rising edge when not in reset:
  - If FlagW[1] & CondEx: {N,Z} <= ALUFlags[3:2].
  - If FlagW[0] & CondEx: {C,V} <= ALUFlags[1:0].
  - Otherwise the flag pair holds its value.
  - The two halves update independently.
- CondExReg: each rising edge when not in reset, CondExReg <= CondEx. There is no enable; the register samples every cycle.
- Outputs are combinational from registered state and inputs, with zero added latency:
  - PCWrite = (PCS & CondExReg) | NextPC
  - RegWrite = RegW & CondExReg
  - MemWrite = MemW & CondExReg
- Latency: a flag write on edge k becomes visible on Flags and in CondEx in cycle k+1. CondExReg reflects those new flags at edge k+1.
- Simultaneous events:
  - If FlagW is active while Cond tests the same flags, CondEx uses the old flags. This is deliberate: the flags are written only when the old condition passes.
  - NextPC=1 forces PCWrite=1 regardless of the condition.
- Reset mid-instruction: flags and CondExReg are cleared. No RegWrite or MemWrite can assert in the cycle after reset, even if RegW or MemW is high.
- No X propagation: every Cond encoding maps to a defined value.

Decomposition:
- Shared package `arm_cond_pkg`:
  - localparams for the 16 Cond encodings (COND_EQ to COND_NV);
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module `condcheck`: purely combinational (Cond, Flags) -> CondEx, instantiated once.
- The top level holds the flag flops, the CondExReg flop and the output gating.

Test Plan:
- Reset: assert reset for 2 cycles with RegW=MemW=PCS=1, NextPC=0 -> Flags=0000, RegWrite=MemWrite=PCWrite=0 in the cycle after reset.
- Flag write then condition: Cond=1110, FlagW=11, ALUFlags=0100 for 1 cycle -> Flags=0100. Next, Cond=0000 (EQ), RegW=1 -> RegWrite=1 one cycle later; with Cond=0001 (NE) -> RegWrite=0.
- Partial update: Flags=1111, Cond=1110, FlagW=10, ALUFlags=0000 -> Flags=0011 (C,V unchanged). Then FlagW=01, ALUFlags=0010 -> Flags=0010.
- Suppressed flag write: Flags=0000, Cond=0000 (EQ fails), FlagW=11, ALUFlags=1100 -> Flags stays 0000, and MemW=1 gives MemWrite=0.
- Signed conditions: Flags=1001 -> GE (1010) passes, LT (1011) fails. Flags=1000 -> GT fails, LE passes. Check each via RegWrite after 1 cycle.
- PC gating: NextPC=1 with CondExReg=0 -> PCWrite=1. NextPC=0, PCS=1, Cond=1111 -> PCWrite=1 on the next cycle. PCS=1 with a failing Cond -> PCWrite=0.

Source files
------------

// File: rtl/arm_cond_pkg.sv
// Shared encodings for the ARM condition field and the {N,Z,C,V} flag nibble.
package arm_cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/condcheck.sv
// Combinational evaluation of a 4-bit condition field against {N,Z,C,V}.
module condcheck
  import arm_cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    CondEx = 1'b1;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      // The reserved encoding behaves as always so the result is never X.
      COND_NV: CondEx = 1'b1;
      default: CondEx = 1'b1;
    endcase
  end

endmodule

// File: rtl/condlogic_mc.sv
// Multicycle ARM condition unit: NZCV flag state, registered condition result
// and final gating of the PC, register-file and memory write enables.
module condlogic_mc
  import arm_cond_pkg::*;
#(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  logic       cond_ex;

  condcheck u_condcheck (
    .Cond   (Cond),
    .Flags  (flags_q),
    .CondEx (cond_ex)
  );

  // Flags are only written when the condition passes against the old flags.
  always_comb begin
    flags_d   = flags_q;
    cond_ex_d = cond_ex;
    if (FlagW[1] && cond_ex) begin
      flags_d[FLAG_N] = ALUFlags[FLAG_N];
      flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
    end
    if (FlagW[0] && cond_ex) begin
      flags_d[FLAG_C] = ALUFlags[FLAG_C];
      flags_d[FLAG_V] = ALUFlags[FLAG_V];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q   <= FLAG_RESET;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign PCWrite  = (PCS & cond_ex_q) | NextPC;
  assign RegWrite = RegW & cond_ex_q;
  assign MemWrite = MemW & cond_ex_q;
  assign Flags    = flags_q;

endmodule

// File: tb/tb_condlogic_mc.sv
// Directed bench for condlogic_mc: the driver pushes the expected
// {Flags, PCWrite, RegWrite, MemWrite} per cycle, a monitor pops and compares.
module tb_condlogic_mc;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, NextPC, RegW, MemW;
  logic       PCWrite, RegWrite, MemWrite;
  logic [3:0] Flags;

  logic [6:0] exp_q[$];
  logic       chk_en;
  int         checks;
  int         errors;
  int         cyc_no;
  logic [15:0] cond_tbl;

  condlogic_mc #(.FLAG_RESET(4'b0000)) dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .NextPC   (NextPC),
    .RegW     (RegW),
    .MemW     (MemW),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .Flags    (Flags)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: sample on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL underflow cycle %0d: no expected entry", cyc_no);
      end else begin
        logic [6:0] exp_v, act_v;
        exp_v = exp_q.pop_front();
        act_v = {Flags, PCWrite, RegWrite, MemWrite};
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL outputs cycle %0d: got flags=%b pc/reg/mem=%b want flags=%b pc/reg/mem=%b",
                   cyc_no, act_v[6:3], act_v[2:0], exp_v[6:3], exp_v[2:0]);
        end
      end
    end
  end

  // driver: apply one cycle of inputs just after the rising edge and queue
  // the outputs expected for that same cycle
  task automatic drive(input logic rst, input logic [3:0] c, input logic [1:0] fw,
                       input logic [3:0] alu, input logic pcs, input logic npc,
                       input logic rw, input logic mw, input logic [6:0] exp_v);
    @(posedge clk);
    #1;
    reset    = rst;
    Cond     = c;
    FlagW    = fw;
    ALUFlags = alu;
    PCS      = pcs;
    NextPC   = npc;
    RegW     = rw;
    MemW     = mw;
    cyc_no++;
    exp_q.push_back(exp_v);
    chk_en = 1'b1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc_no   = 0;
    chk_en   = 1'b0;
    // result of every Cond encoding with Flags=0000, bit i = encoding i
    cond_tbl = 16'b1101_0110_1010_1010;
    reset    = 1'b1;
    Cond     = 4'b1110;
    FlagW    = 2'b00;
    ALUFlags = 4'b0000;
    PCS      = 1'b1;
    NextPC   = 1'b0;
    RegW     = 1'b1;
    MemW     = 1'b1;
    @(posedge clk);

    // reset held for two edges with RegW/MemW/PCS high
    drive(0, 4'b1110, 2'b00, 4'b0000, 1, 0, 1, 1, 7'b0000_000);

    // flag write then EQ / NE
    drive(0, 4'b1110, 2'b11, 4'b0100, 0, 0, 0, 0, 7'b0000_000);
    drive(0, 4'b0000, 2'b00, 4'b0000, 0, 0, 0, 0, 7'b0100_000);
    drive(0, 4'b0001, 2'b00, 4'b0000, 0, 0, 1, 0, 7'b0100_010);
    drive(0, 4'b1110, 2'b00, 4'b0000, 0, 0, 1, 0, 7'b0100_000);

    // partial updates
    drive(0, 4'b1110, 2'b11, 4'b1111, 0, 0, 0, 0, 7'b0100_000);
    drive(0, 4'b1110, 2'b10, 4'b0000, 0, 0, 0, 0, 7'b1111_000);
    drive(0, 4'b1110, 2'b01, 4'b0010, 0, 0, 0, 0, 7'b0011_000);
    drive(0, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0, 7'b0010_000);

    // suppressed flag write, MemWrite gating
    drive(0, 4'b1110, 2'b11, 4'b0000, 0, 0, 0, 0, 7'b0010_000);
    drive(0, 4'b0000, 2'b11, 4'b1100, 0, 0, 0, 0, 7'b0000_000);
    drive(0, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 1, 7'b0000_000);
    drive(0, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 1, 7'b0000_001);

    // signed conditions: Flags=1001 GE/LT, Flags=1000 GT/LE
    drive(0, 4'b1110, 2'b11, 4'b1001, 0, 0, 0, 0, 7'b0000_000);
    drive(0, 4'b1010, 2'b00, 4'b0000, 0, 0, 0, 0, 7'b1001_000);
    drive(0, 4'b1011, 2'b00, 4'b0000, 0, 0, 1, 0, 7'b1001_010);
    drive(0, 4'b1110, 2'b00, 4'b0000, 0, 0, 1, 0, 7'b1001_000);
    drive(0, 4'b1110, 2'b11, 4'b1000, 0, 0, 0, 0, 7'b1001_000);
    drive(0, 4'b1100, 2'b00, 4'b0000, 0, 0, 0, 0, 7'b1000_000);
    drive(0, 4'b1101, 2'b00, 4'b0000, 0, 0, 1, 0, 7'b1000_000);
    drive(0, 4'b1110, 2'b00, 4'b0000, 0, 0, 1, 0, 7'b1000_010);

    // PC gating
    drive(0, 4'b0000, 2'b00, 4'b0000, 0, 0, 0, 0, 7'b1000_000);
    drive(0, 4'b1111, 2'b00, 4'b0000, 0, 1, 0, 0, 7'b1000_100);
    drive(0, 4'b0000, 2'b00, 4'b0000, 1, 0, 0, 0, 7'b1000_100);
    drive(0, 4'b1110, 2'b00, 4'b0000, 1, 0, 0, 0, 7'b1000_000);

    // reset mid-instruction with RegW/MemW high
    drive(1, 4'b1110, 2'b00, 4'b0000, 0, 0, 1, 1, 7'b1000_011);
    drive(0, 4'b1110, 2'b00, 4'b0000, 1, 0, 1, 1, 7'b0000_000);

    // sweep every encoding with Flags=0000, observed via RegWrite a cycle later
    for (int i = 0; i <= 16; i++) begin
      logic [3:0] c;
      logic       prev;
      c    = (i < 16) ? 4'(i) : 4'b1110;
      prev = (i == 0) ? 1'b1 : cond_tbl[i-1];
      drive(0, c, 2'b00, 4'b0000, 0, 0, 1, 0, {4'b0000, 1'b0, prev, 1'b0});
    end

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
